// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-write buffer sitting between the MEM stage and a slow data-memory
//   port. Stores are accepted in one cycle, kept in a circular array and
//   retired in order over a MemReq/MemAck handshake. Loads that hit a pending
//   store get the buffered bytes forwarded, youngest entry winning per byte.
//   A store to the youngest non-head entry's address merges into it.
//
// Ports
//   CLK, Reset            clock, asynchronous active-high reset
//   StWrite/StAddr/StData/StBE   MEM-stage store request
//   LdCheck/LdAddr        MEM-stage load lookup
//   LdHit/LdData/LdBE     forwarding result
//   Full/Empty/Count      occupancy
//   MemReq/MemAddr/MemData/MemBE/MemAck   drain handshake (head entry)
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     StWrite,
  input  logic [AW-1:0]            StAddr,
  input  logic [DW-1:0]            StData,
  input  logic [DW/8-1:0]          StBE,
  input  logic                     LdCheck,
  input  logic [AW-1:0]            LdAddr,
  output logic                     LdHit,
  output logic [DW-1:0]            LdData,
  output logic [DW/8-1:0]          LdBE,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     MemReq,
  output logic [AW-1:0]            MemAddr,
  output logic [DW-1:0]            MemData,
  output logic [DW/8-1:0]          MemBE,
  input  logic                     MemAck
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = DW / 8;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [BW-1:0] r_be   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_merge;
  logic          w_push;
  logic [PW-1:0] w_young;
  logic [PW-1:0] w_fwd_idx;
  logic          w_any_hit;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && MemAck;
  assign w_young = r_tail - PW'(1);

  // Merging needs no free slot, so it is decided before the space check.
  // Count>=2 keeps the head (which may be mid-handshake) untouched.
  assign w_merge = StWrite && (r_count >= CW'(2)) && (r_addr[w_young] == StAddr);
  assign w_push  = StWrite && !w_merge && (!w_full || w_pop);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push) begin
        r_addr[r_tail] <= StAddr;
        r_data[r_tail] <= StData;
        r_be[r_tail]   <= StBE;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_merge) begin
        for (int unsigned b = 0; b < BW; b++) begin
          if (StBE[b]) begin
            r_data[w_young][8*b +: 8] <= StData[8*b +: 8];
            r_be[w_young][b]          <= 1'b1;
          end
        end
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Drain side: head entry presented whenever the buffer is non-empty.
  always_comb begin
    MemReq  = !w_empty;
    MemAddr = '0;
    MemData = '0;
    MemBE   = '0;
    if (!w_empty) begin
      MemAddr = r_addr[r_head];
      MemData = r_data[r_head];
      MemBE   = r_be[r_head];
    end
  end

  // Forwarding: walk oldest to youngest so later matches overwrite per byte.
  always_comb begin
    LdData    = '0;
    LdBE      = '0;
    w_any_hit = 1'b0;
    w_fwd_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_fwd_idx] == LdAddr)) begin
        w_any_hit = 1'b1;
        for (int unsigned b = 0; b < BW; b++) begin
          if (r_be[w_fwd_idx][b]) begin
            LdData[8*b +: 8] = r_data[w_fwd_idx][8*b +: 8];
            LdBE[b]          = 1'b1;
          end
        end
      end
    end
    LdHit = LdCheck && w_any_hit;
  end

  assign Full  = w_full;
  assign Empty = w_empty;
  assign Count = r_count;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;

  logic                   CLK;
  logic                   Reset;
  logic                   StWrite;
  logic [AW-1:0]          StAddr;
  logic [DW-1:0]          StData;
  logic [BW-1:0]          StBE;
  logic                   LdCheck;
  logic [AW-1:0]          LdAddr;
  logic                   LdHit;
  logic [DW-1:0]          LdData;
  logic [BW-1:0]          LdBE;
  logic                   Full;
  logic                   Empty;
  logic [$clog2(DEPTH):0] Count;
  logic                   MemReq;
  logic [AW-1:0]          MemAddr;
  logic [DW-1:0]          MemData;
  logic [BW-1:0]          MemBE;
  logic                   MemAck;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } ent_t;

  // Reference model: ordered list of pending stores, oldest first.
  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .Reset(Reset),
    .StWrite(StWrite), .StAddr(StAddr), .StData(StData), .StBE(StBE),
    .LdCheck(LdCheck), .LdAddr(LdAddr),
    .LdHit(LdHit), .LdData(LdData), .LdBE(LdBE),
    .Full(Full), .Empty(Empty), .Count(Count),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemBE(MemBE),
    .MemAck(MemAck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the pending-store list implies.
  task automatic check_model();
    logic          hit;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    hit = 1'b0;
    d   = '0;
    be  = '0;
    foreach (q[k]) begin
      if (q[k].addr == LdAddr) begin
        hit = 1'b1;
        for (int b = 0; b < BW; b++) begin
          if (q[k].be[b]) begin
            d[8*b +: 8] = q[k].data[8*b +: 8];
            be[b]       = 1'b1;
          end
        end
      end
    end
    chk("count",   Count,  q.size());
    chk("empty",   Empty,  q.size() == 0);
    chk("full",    Full,   q.size() == DEPTH);
    chk("memreq",  MemReq, q.size() != 0);
    chk("memaddr", MemAddr, (q.size() != 0) ? q[0].addr : '0);
    chk("memdata", MemData, (q.size() != 0) ? q[0].data : '0);
    chk("membe",   MemBE,   (q.size() != 0) ? q[0].be   : '0);
    chk("ldhit",   LdHit,  LdCheck && hit);
    chk("lddata",  LdData, d);
    chk("ldbe",    LdBE,   be);
  endtask

  // One clock: drive at posedge+1, check pre-edge state, clock, update model.
  task automatic step(input logic stw, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input logic [BW-1:0] sbe, input logic ldc, input logic [AW-1:0] la,
                      input logic ack);
    logic pop, merge, push;
    ent_t e;
    StWrite = stw; StAddr = sa; StData = sd; StBE = sbe;
    LdCheck = ldc; LdAddr = la; MemAck = ack;
    #1;
    check_model();
    pop   = (q.size() != 0) && ack;
    merge = stw && (q.size() >= 2) && (q[$].addr == sa);
    push  = stw && !merge && ((q.size() < DEPTH) || pop);
    @(posedge CLK);
    if (merge) begin
      e = q[$];
      for (int b = 0; b < BW; b++) begin
        if (sbe[b]) begin
          e.data[8*b +: 8] = sd[8*b +: 8];
          e.be[b]          = 1'b1;
        end
      end
      q[q.size()-1] = e;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      e.addr = sa; e.data = sd; e.be = sbe;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2*DEPTH; i++) begin
      if (q.size() != 0) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    end
    chk("drain_empty", Empty, 1'b1);
  endtask

  logic [AW-1:0] sa_r;
  logic          stw_r, ack_r;

  initial begin
    StWrite = 1'b0; StAddr = '0; StData = '0; StBE = '0;
    LdCheck = 1'b1; LdAddr = '0; MemAck = 1'b0;
    Reset = 1'b1;
    #12;
    check_model();
    chk("rst_memreq", MemReq, 1'b0);
    chk("rst_empty",  Empty,  1'b1);
    Reset = 1'b0;
    @(posedge CLK); #1;

    // Reset in the middle of operation
    step(1'b1, 10'h100, 32'h0000_0100, 4'hF, 1'b0, '0, 1'b0);
    step(1'b1, 10'h101, 32'h0000_0101, 4'hF, 1'b0, '0, 1'b0);
    step(1'b1, 10'h102, 32'h0000_0102, 4'hF, 1'b0, '0, 1'b0);
    chk("mid_count3", Count, 3);
    StWrite = 1'b0; LdCheck = 1'b1; LdAddr = 10'h100;
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_memreq", MemReq, 1'b0);
    chk("mid_rst_empty",  Empty,  1'b1);
    chk("mid_rst_count",  Count,  0);
    chk("mid_rst_ldhit",  LdHit,  1'b0);
    chk("mid_rst_ldbe",   LdBE,   4'h0);
    chk("mid_rst_membus", {MemAddr, MemData, MemBE}, '0);
    q.delete();
    #1 Reset = 1'b0;
    @(posedge CLK); #1;
    step(1'b0, '0, '0, '0, 1'b1, 10'h100, 1'b1);
    chk("rst_noack_count", Count, 0);

    // In-order drain with MemAck held high
    step(1'b1, 10'h010, 32'hAAAA_0001, 4'hF, 1'b0, '0, 1'b1);
    chk("drain_first",  MemAddr, 10'h010);
    step(1'b1, 10'h011, 32'hBBBB_0002, 4'hF, 1'b0, '0, 1'b1);
    chk("drain_second", MemAddr, 10'h011);
    chk("drain_second_d", MemData, 32'hBBBB_0002);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    chk("drain_done", MemReq, 1'b0);

    // Full, dropped store, simultaneous push/pop with tail wrap
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 10'h200 + 10'(i), 32'h2000_0000 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
    chk("full_set", Full, 1'b1);
    step(1'b1, 10'h210, 32'hDEAD_BEEF, 4'hF, 1'b1, 10'h210, 1'b0);
    chk("full_drop_count", Count, 4);
    chk("full_drop_nohit", LdHit, 1'b0);
    step(1'b1, 10'h211, 32'h2110_0000, 4'hF, 1'b1, 10'h211, 1'b1);
    chk("full_pp_count", Count, 4);
    chk("full_pp_head",  MemAddr, 10'h201);
    chk("full_pp_fwd",   LdData, 32'h2110_0000);
    drain();

    // Coalescing into the youngest non-head entry
    step(1'b1, 10'h020, 32'h0202_0202, 4'hF, 1'b0, '0, 1'b0);
    step(1'b1, 10'h030, 32'h1122_3344, 4'h3, 1'b0, '0, 1'b0);
    step(1'b1, 10'h030, 32'hAABB_CCDD, 4'hC, 1'b1, 10'h030, 1'b0);
    chk("coal_count", Count, 2);
    chk("coal_data",  LdData, 32'hAABB_3344);
    chk("coal_be",    LdBE,   4'hF);
    chk("coal_head",  MemAddr, 10'h020);
    drain();

    // Forwarding priority: youngest match wins per byte
    step(1'b1, 10'h040, 32'h1111_1111, 4'hF, 1'b0, '0, 1'b0);
    step(1'b1, 10'h050, 32'h5050_5050, 4'hF, 1'b0, '0, 1'b0);
    step(1'b1, 10'h040, 32'h2222_2222, 4'h1, 1'b1, 10'h040, 1'b0);
    chk("fwd_hit",  LdHit,  1'b1);
    chk("fwd_data", LdData, 32'h1111_1122);
    chk("fwd_be",   LdBE,   4'hF);
    LdAddr = 10'h041; #1;
    chk("fwd_miss_hit", LdHit, 1'b0);
    chk("fwd_miss_be",  LdBE,  4'h0);
    LdAddr = 10'h040; LdCheck = 1'b0; #1;
    chk("fwd_nochk_hit", LdHit, 1'b0);
    chk("fwd_nochk_be",  LdBE,  4'hF);
    drain();

    // Head stays stable while MemAck is low and younger stores arrive
    step(1'b1, 10'h060, 32'hCAFE_F00D, 4'h5, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b1, 10'h061 + 10'(i), 32'h6100_0000 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
      else       step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      chk("stable_addr", MemAddr, 10'h060);
      chk("stable_data", MemData, 32'hCAFE_F00D);
      chk("stable_be",   MemBE,   4'h5);
    end
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    chk("stable_next", MemAddr, 10'h061);
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ack_r = ($urandom_range(0, 2) == 0);
      stw_r = ($urandom_range(0, 1) == 1);
      sa_r  = 10'h040 + 10'($urandom_range(0, 3));
      if (q.size() == DEPTH && !ack_r) stw_r = 1'b0;
      step(stw_r, sa_r, $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
           10'h040 + 10'($urandom_range(0, 4)), ack_r);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
